// File: rtl/ccff_prog_ctrl_if.sv
// Bitstream handshake plus start/status bundle between a bitstream source and ccff_prog_ctrl.
// The master side is the source (host bridge / ROM reader); the slave side is the controller.
interface ccff_prog_ctrl_if #(
    parameter int unsigned WORD_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic              error;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (
        output start,
        output word_valid,
        output word_data,
        input  busy,
        input  done,
        input  error,
        input  word_ready
    );

    modport slave (
        input  start,
        input  word_valid,
        input  word_data,
        output busy,
        output done,
        output error,
        output word_ready
    );
endinterface

// File: rtl/ccff_prog_ctrl.sv
// Serializes a word-wide bitstream into the configuration flip-flop chain, LSB first.
// Define CCFF_CRC_EN to add a trailing CRC-16-CCITT check word after the chain data.
module ccff_prog_ctrl #(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic            prog_clk,
    input  logic            pReset_n,
    ccff_prog_ctrl_if.slave bus,
    output logic            ccff_head,
    output logic            ccff_shift_en
);

    localparam int unsigned      REM_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);

`ifdef CCFF_CRC_EN
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StShift = 3'd2,
        StCrc   = 3'd3,
        StDone  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StShift = 3'd2,
        StDone  = 3'd4
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic [31:0]       left_w;
    logic [31:0]       k_w;

    // Status outputs decode straight from the state register.
    always_comb begin
        bus.done = (state_q == StDone);
`ifdef CCFF_CRC_EN
        bus.word_ready = (state_q == StLoad) || (state_q == StCrc);
        bus.busy       = (state_q == StLoad) || (state_q == StShift) || (state_q == StCrc);
`else
        bus.word_ready = (state_q == StLoad);
        bus.busy       = (state_q == StLoad) || (state_q == StShift);
`endif
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;

    // Bits this word contributes: a full word, or whatever is left of the chain.
    always_comb begin
        left_w = 32'(CHAIN_LEN) - 32'(cnt_q);
        k_w    = (left_w < 32'(WORD_W)) ? left_w : 32'(WORD_W);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        rem_d      = rem_q;
        head_d     = 1'b0;
        shift_en_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (bus.word_valid) begin
                    // First bit goes out on the registered pins right away.
                    head_d     = bus.word_data[0];
                    shift_en_d = 1'b1;
                    sreg_d     = bus.word_data >> 1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    rem_d      = REM_W'(k_w - 32'd1);
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (rem_q != '0) begin
                    head_d     = sreg_q[0];
                    shift_en_d = 1'b1;
                    sreg_d     = sreg_q >> 1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    rem_d      = rem_q - REM_W'(1);
                end else if (cnt_q == CHAIN_END) begin
`ifdef CCFF_CRC_EN
                    state_d = StCrc;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StLoad;
                end
            end
`ifdef CCFF_CRC_EN
            StCrc: begin
                if (bus.word_valid) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sreg_q     <= '0;
            rem_q      <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            rem_q      <= rem_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
        end
    end

`ifdef CCFF_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        err_q, err_d;

    // CRC runs over exactly the bits the chain sees, i.e. head while shift_en is high.
    always_comb begin
        crc_d = crc_q;
        err_d = err_q;
        if ((state_q == StIdle) && bus.start) begin
            crc_d = 16'hFFFF;
            err_d = 1'b0;
        end else if (shift_en_q) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ head_q) ? 16'h1021 : 16'h0000);
        end
        if ((state_q == StCrc) && bus.word_valid) begin
            err_d = (bus.word_data[15:0] != crc_q);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            crc_q <= 16'hFFFF;
            err_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            err_q <= err_d;
        end
    end

    assign bus.error = (state_q == StDone) && err_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule
